// File: rtl/mm_arb_pkg.sv
// rtl/mm_arb_pkg.sv - shared types and defaults for the two-requester main-memory arbiter
//
// Contents:
//   MM_ADDR_W_DEFAULT / MM_DATA_W_DEFAULT : default word-address and data widths
//   state_e : transaction FSM states (IDLE, ISSUE, BUSY, DONE)
//   op_e    : latched memory operation (OP_READ, OP_WRITE)
//   RR_EN   : 1 when MM_ARB_ROUND_ROBIN_EN is defined (round-robin tie break),
//             0 otherwise (fixed priority, requester 0 wins ties)

package mm_arb_pkg;

    localparam int MM_ADDR_W_DEFAULT = 15;
    localparam int MM_DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

`ifdef MM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

endpackage

// File: rtl/mm_arb_pick.sv
// rtl/mm_arb_pick.sv - two-way grant picker for the main-memory arbiter
//
// Tie-break policy follows mm_arb_pkg::RR_EN, which is set by MM_ARB_ROUND_ROBIN_EN:
//   defined   : on a tie the requester that was not granted last wins
//   undefined : requester 0 always wins a tie
//
// Ports:
//   req_i        in  [1:0] pending request per requester (bit 0 = c0, bit 1 = c1)
//   last_grant_i in  1     requester served by the most recent completed transaction
//   valid_o      out 1     at least one request is pending
//   grant_o      out 1     index of the winning requester (meaningful when valid_o)

module mm_arb_pick
    import mm_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       valid_o,
    output logic       grant_o
);

    always_comb begin
        valid_o = |req_i;
        grant_o = 1'b0;
        if (req_i == 2'b10) begin
            grant_o = 1'b1;
        end else if (req_i == 2'b11) begin
            // Fixed priority leaves the tie with requester 0.
            grant_o = RR_EN ? ~last_grant_i : 1'b0;
        end
    end

endmodule

// File: rtl/mm_arbiter.sv
// rtl/mm_arbiter.sv - arbitrates two requesters onto a single main-memory port
//
// One transaction at a time: IDLE arbitrates and latches the winner's op,
// address and write data; ISSUE drives the memory request until MM_busy rises;
// BUSY holds it until MM_busy falls; DONE pulses the winner's done.
// Optional feature: MM_ARB_ROUND_ROBIN_EN (round-robin tie break, see mm_arb_pick).
//
// Ports:
//   clk, reset                    clock; asynchronous active-high reset
//   cX_read_request  in  1        requester X read, held until cX_done
//   cX_write_request in  1        requester X write, held until cX_done (wins over read)
//   cX_word_address  in  ADDR_W   requester X word address
//   cX_wdata         in  n        requester X write data
//   cX_rdata         out n        requester X read data, valid with cX_done, held otherwise
//   cX_done          out 1        one-cycle completion pulse to requester X
//   L2_read_request  out 1        read request to main memory
//   L2_write_request out 1        write request to main memory
//   L2_word_address  out ADDR_W   latched address to main memory
//   L2_wdata         out n        latched write data to main memory
//   L2_rdata         in  n        read data from main memory
//   MM_busy          in  1        main memory busy flag
//   grant_id         out 1        requester owning the current transaction

module mm_arbiter
    import mm_arb_pkg::*;
#(
    parameter int n      = MM_DATA_W_DEFAULT,
    parameter int ADDR_W = MM_ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              c0_read_request,
    input  logic              c0_write_request,
    input  logic [ADDR_W-1:0] c0_word_address,
    input  logic [n-1:0]      c0_wdata,
    output logic [n-1:0]      c0_rdata,
    output logic              c0_done,

    input  logic              c1_read_request,
    input  logic              c1_write_request,
    input  logic [ADDR_W-1:0] c1_word_address,
    input  logic [n-1:0]      c1_wdata,
    output logic [n-1:0]      c1_rdata,
    output logic              c1_done,

    output logic              L2_read_request,
    output logic              L2_write_request,
    output logic [ADDR_W-1:0] L2_word_address,
    output logic [n-1:0]      L2_wdata,
    input  logic [n-1:0]      L2_rdata,
    input  logic              MM_busy,

    output logic              grant_id
);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [n-1:0]        wdata_q, wdata_d;
    logic [n-1:0]        c0_rdata_q, c0_rdata_d;
    logic [n-1:0]        c1_rdata_q, c1_rdata_d;

    logic [1:0]          req;
    logic                pick_valid;
    logic                pick_grant;

    assign req = {c1_read_request | c1_write_request,
                  c0_read_request | c0_write_request};

    mm_arb_pick u_pick (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .grant_o      (pick_grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= OP_READ;
            grant_q      <= 1'b0;
            // "Last granted = 1" makes the round-robin pointer favour requester 0.
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            c0_rdata_q   <= '0;
            c1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            c0_rdata_q   <= c0_rdata_d;
            c1_rdata_q   <= c1_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        c0_rdata_d   = c0_rdata_q;
        c1_rdata_d   = c1_rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    if (pick_grant) begin
                        op_d    = c1_write_request ? OP_WRITE : OP_READ;
                        addr_d  = c1_word_address;
                        wdata_d = c1_wdata;
                    end else begin
                        op_d    = c0_write_request ? OP_WRITE : OP_READ;
                        addr_d  = c0_word_address;
                        wdata_d = c0_wdata;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (MM_busy) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!MM_busy) begin
                    state_d = DONE;
                    // Capture on entry to DONE so the read data is already
                    // present on cX_rdata in the same cycle as cX_done.
                    if (op_q == OP_READ) begin
                        if (grant_q) begin
                            c1_rdata_d = L2_rdata;
                        end else begin
                            c0_rdata_d = L2_rdata;
                        end
                    end
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The memory request is a pure function of flopped state, so requesters
    // changing or dropping their inputs cannot disturb an issued transaction.
    logic mem_active;
    assign mem_active       = (state_q == ISSUE) || (state_q == BUSY);
    assign L2_read_request  = mem_active && (op_q == OP_READ);
    assign L2_write_request = mem_active && (op_q == OP_WRITE);
    assign L2_word_address  = addr_q;
    assign L2_wdata         = wdata_q;

    assign c0_done  = (state_q == DONE) && !grant_q;
    assign c1_done  = (state_q == DONE) &&  grant_q;
    assign c0_rdata = c0_rdata_q;
    assign c1_rdata = c1_rdata_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_mm_arbiter.sv
// tb/tb_mm_arbiter.sv - self-checking bench for mm_arbiter with a behavioural memory and arbitration model
`timescale 1ns/1ps

module tb_mm_arbiter;

    localparam int N  = 32;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          c0_read_request, c0_write_request, c1_read_request, c1_write_request;
    logic [AW-1:0] c0_word_address, c1_word_address, L2_word_address;
    logic [N-1:0]  c0_wdata, c1_wdata, c0_rdata, c1_rdata, L2_wdata, L2_rdata;
    logic          c0_done, c1_done, L2_read_request, L2_write_request, MM_busy, grant_id;

    mm_arbiter #(.n(N), .ADDR_W(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .c0_read_request  (c0_read_request),
        .c0_write_request (c0_write_request),
        .c0_word_address  (c0_word_address),
        .c0_wdata         (c0_wdata),
        .c0_rdata         (c0_rdata),
        .c0_done          (c0_done),
        .c1_read_request  (c1_read_request),
        .c1_write_request (c1_write_request),
        .c1_word_address  (c1_word_address),
        .c1_wdata         (c1_wdata),
        .c1_rdata         (c1_rdata),
        .c1_done          (c1_done),
        .L2_read_request  (L2_read_request),
        .L2_write_request (L2_write_request),
        .L2_word_address  (L2_word_address),
        .L2_wdata         (L2_wdata),
        .L2_rdata         (L2_rdata),
        .MM_busy          (MM_busy),
        .grant_id         (grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // op: 0 = read, 1 = write, 2 = read and write together (served as write)
    typedef struct {
        int            op;
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
    } desc_t;

    desc_t        q0[$];
    desc_t        q1[$];
    logic [N-1:0] mem [int];
    logic [N-1:0] ref_mem [int];
    logic [N-1:0] exp_rdata [2];
    int           model_last;
    int           busy_min = 1, busy_max = 4, busy_left = 0, last_busy = 0;
    bit           armed = 0;

    // Main memory: accepts a request in its first cycle, raises MM_busy the
    // cycle after for a random number of cycles, then drops it.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            MM_busy   = 1'b0;
            busy_left = 0;
            armed     = 1'b0;
        end else if (L2_read_request || L2_write_request) begin
            if (!armed) begin
                armed     = 1'b1;
                busy_left = $urandom_range(busy_max, busy_min);
                last_busy = busy_left;
                MM_busy   = 1'b0;
                if (L2_write_request) mem[int'(L2_word_address)] = L2_wdata;
            end else if (busy_left > 0) begin
                MM_busy = 1'b1;
                busy_left--;
            end else begin
                MM_busy = 1'b0;
            end
        end else begin
            armed   = 1'b0;
            MM_busy = 1'b0;
        end
        L2_rdata = mem.exists(int'(L2_word_address)) ? mem[int'(L2_word_address)] : '0;
    end

    function automatic desc_t mk(input int op, input logic [AW-1:0] addr, input logic [N-1:0] data);
        desc_t d;
        d.op = op; d.addr = addr; d.data = data;
        return d;
    endfunction

    function automatic desc_t rnd_desc();
        return mk($urandom_range(2, 0), AW'($urandom_range(7, 0)), $urandom);
    endfunction

    function automatic logic [N-1:0] ref_read(input logic [AW-1:0] addr);
        return ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : '0;
    endfunction

    function automatic int pick_model(input bit p0, input bit p1, input int last);
        int rr = 0;
`ifdef MM_ARB_ROUND_ROBIN_EN
        rr = 1;
`endif
        if (p0 && p1) return (rr == 1 && last == 0) ? 1 : 0;
        return p0 ? 0 : 1;
    endfunction

    task automatic present(input int who, input desc_t d);
        if (who == 0) begin
            c0_read_request = (d.op != 1); c0_write_request = (d.op != 0);
            c0_word_address = d.addr;      c0_wdata = d.data;
        end else begin
            c1_read_request = (d.op != 1); c1_write_request = (d.op != 0);
            c1_word_address = d.addr;      c1_wdata = d.data;
        end
    endtask

    task automatic drop(input int who);
        if (who == 0) begin c0_read_request = 1'b0; c0_write_request = 1'b0; end
        else          begin c1_read_request = 1'b0; c1_write_request = 1'b0; end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        drop(0); drop(1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_last   = 1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    // Serves everything queued in q0/q1; a requester presents its next entry
    // in the cycle its done pulse is seen, so both compete at every IDLE.
    task automatic run_queues(input string name, input bit drop_mid);
        int    exp_order[$];
        int    n0, n1, last, k, i0, i1, cyc, issue_cyc, owner, who, budget;
        bit    prev_l2, l2;
        desc_t d;
        n0 = q0.size(); n1 = q1.size(); last = model_last;
        while (n0 > 0 || n1 > 0) begin
            owner = pick_model(n0 > 0, n1 > 0, last);
            exp_order.push_back(owner);
            if (owner == 0) n0--; else n1--;
            last = owner;
        end
        k = 0; i0 = 0; i1 = 0; cyc = 0; issue_cyc = 0; prev_l2 = 1'b0;
        budget = 40 * (exp_order.size() + 1);
        @(negedge clk);
        if (q0.size() > 0) present(0, q0[0]);
        if (q1.size() > 0) present(1, q1[0]);
        while (k < exp_order.size() && cyc < budget) begin
            @(negedge clk);
            cyc++;
            l2 = L2_read_request | L2_write_request;
            if (MM_busy) begin
                checks++; if (!l2) $display("FAIL %s hold: L2 request=%0b while MM_busy, want 1", name, l2); else passes++;
            end
            if (l2 && !prev_l2) begin
                owner = exp_order[k];
                d = (owner == 0) ? q0[i0] : q1[i1];
                checks++; if (grant_id !== owner[0]) $display("FAIL %s grant_id: got %0b want %0d", name, grant_id, owner); else passes++;
                checks++; if (L2_write_request !== (d.op != 0) || L2_read_request !== (d.op == 0))
                    $display("FAIL %s op: got rd=%0b wr=%0b want op %0d", name, L2_read_request, L2_write_request, d.op); else passes++;
                checks++; if (L2_word_address !== d.addr) $display("FAIL %s addr: got %h want %h", name, L2_word_address, d.addr); else passes++;
                if (d.op != 0) begin
                    checks++; if (L2_wdata !== d.data) $display("FAIL %s wdata: got %h want %h", name, L2_wdata, d.data); else passes++;
                end
                issue_cyc = cyc;
                if (drop_mid) drop(owner);
            end
            prev_l2 = l2;
            if (c0_done || c1_done) begin
                owner = exp_order[k];
                who   = c1_done ? 1 : 0;
                checks++; if ((c0_done && c1_done) || who != owner)
                    $display("FAIL %s order #%0d: got c0_done=%0b c1_done=%0b want c%0d", name, k, c0_done, c1_done, owner); else passes++;
                checks++; if (cyc - issue_cyc != last_busy + 2)
                    $display("FAIL %s latency: got %0d want %0d", name, cyc - issue_cyc, last_busy + 2); else passes++;
                d = (owner == 0) ? q0[i0] : q1[i1];
                if (d.op == 0) exp_rdata[owner] = ref_read(d.addr);
                else           ref_mem[int'(d.addr)] = d.data;
                checks++; if (c0_rdata !== exp_rdata[0]) $display("FAIL %s c0_rdata: got %h want %h", name, c0_rdata, exp_rdata[0]); else passes++;
                checks++; if (c1_rdata !== exp_rdata[1]) $display("FAIL %s c1_rdata: got %h want %h", name, c1_rdata, exp_rdata[1]); else passes++;
                if (owner == 0) begin i0++; if (i0 < q0.size()) present(0, q0[i0]); else drop(0); end
                else            begin i1++; if (i1 < q1.size()) present(1, q1[i1]); else drop(1); end
                model_last = owner;
                k++;
            end
        end
        checks++; if (k != exp_order.size()) $display("FAIL %s timeout: got %0d dones want %0d", name, k, exp_order.size()); else passes++;
        drop(0); drop(1);
        @(negedge clk);
        checks++; if (c0_done !== 1'b0 || c1_done !== 1'b0)
            $display("FAIL %s stray done: got c0=%0b c1=%0b want 0", name, c0_done, c1_done); else passes++;
        q0.delete(); q1.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        checks++; if (L2_read_request !== 1'b0)  $display("FAIL %s L2_read_request: got %0b want 0", name, L2_read_request); else passes++;
        checks++; if (L2_write_request !== 1'b0) $display("FAIL %s L2_write_request: got %0b want 0", name, L2_write_request); else passes++;
        checks++; if (L2_word_address !== '0)    $display("FAIL %s L2_word_address: got %h want 0", name, L2_word_address); else passes++;
        checks++; if (L2_wdata !== '0)           $display("FAIL %s L2_wdata: got %h want 0", name, L2_wdata); else passes++;
        checks++; if (c0_done !== 1'b0 || c1_done !== 1'b0) $display("FAIL %s done: got %0b%0b want 00", name, c0_done, c1_done); else passes++;
        checks++; if (c0_rdata !== '0 || c1_rdata !== '0) $display("FAIL %s rdata: got %h/%h want 0", name, c0_rdata, c1_rdata); else passes++;
        checks++; if (grant_id !== 1'b0)         $display("FAIL %s grant_id: got %0b want 0", name, grant_id); else passes++;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        check_idle_outputs("reset");
    endtask

    task automatic test_write_max();
        busy_min = 3; busy_max = 3;
        q0.push_back(mk(1, 15'h7FFF, 32'd123456));
        run_queues("write_max", 1'b0);
    endtask

    task automatic test_read_c1();
        busy_min = 1; busy_max = 4;
        mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
        q1.push_back(mk(0, 15'h0010, '0));
        run_queues("read_c1", 1'b0);
    endtask

    task automatic test_rw_both();
        q0.push_back(mk(0, 15'h0010, '0));
        q0.push_back(mk(2, 15'h0010, 32'hA5A5_0F0F));
        q0.push_back(mk(0, 15'h0010, '0));
        run_queues("rw_both", 1'b0);
    endtask

    task automatic test_tie();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(rnd_desc());
            q1.push_back(rnd_desc());
        end
        run_queues("tie", 1'b0);
    endtask

    task automatic test_drop();
        for (int i = 0; i < 2; i++) begin
            q0.push_back(rnd_desc());
            q1.push_back(rnd_desc());
        end
        run_queues("drop_mid", 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            busy_min = 1; busy_max = $urandom_range(5, 1);
            for (int i = $urandom_range(3, 0); i > 0; i--) q0.push_back(rnd_desc());
            for (int i = $urandom_range(3, 0); i > 0; i--) q1.push_back(rnd_desc());
            run_queues("random", 1'($urandom_range(1, 0)));
        end
    endtask

    task automatic test_reset_busy();
        int  waited;
        int  bad;
        busy_min = 6; busy_max = 6;
        @(negedge clk);
        present(0, mk(1, 15'h4000, 32'h1234_5678));
        waited = 0;
        while (!MM_busy && waited < 20) begin @(negedge clk); waited++; end
        checks++; if (!MM_busy) $display("FAIL reset_busy reach: got MM_busy=%0b want 1", MM_busy); else passes++;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_idle_outputs("reset_busy");
        drop(0); drop(1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_last = 1; exp_rdata[0] = '0; exp_rdata[1] = '0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (c0_done || c1_done || L2_read_request || L2_write_request) bad++;
        end
        checks++; if (bad != 0) $display("FAIL reset_busy quiet: got %0d active cycles want 0", bad); else passes++;
        busy_min = 1; busy_max = 3;
        q0.push_back(mk(1, 15'h0006, 32'h0BAD_CAFE));
        q1.push_back(mk(0, 15'h0006, '0));
        run_queues("after_reset", 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        c0_read_request = 1'b0; c0_write_request = 1'b0; c0_word_address = '0; c0_wdata = '0;
        c1_read_request = 1'b0; c1_write_request = 1'b0; c1_word_address = '0; c1_wdata = '0;
        MM_busy = 1'b0; L2_rdata = '0;
        model_last = 1; exp_rdata[0] = '0; exp_rdata[1] = '0;
        test_reset();
        test_write_max();
        test_read_c1();
        test_rw_both();
        test_tie();
        test_drop();
        test_random();
        test_reset_busy();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
